altmemddr_ex_lfsr8_checker: RTL and testbench

//   Read-side pattern checker for the altmemddr example driver. Compares read-back bytes with the
//   8-bit LFSR sequence the write-side generator produced: x^8+x^4+x^3+x^2+1.

---
 rtl/altmemddr_ex_lfsr8_checker.sv | 155 +++++++++++++++
 tb/tb_altmemddr_ex_lfsr8_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/altmemddr_ex_lfsr8_checker.sv
// Purpose : read-side checker comparing read-back bytes against the x^8+x^4+x^3+x^2+1 LFSR stream per lane.
// Latency : every status output updates on the edge that samples a beat and is visible the following cycle.
// Backpr. : none; a valid beat is accepted every cycle it is presented (ALTMEMDDR_CHK_RESYNC_EN: beat 0 reseeds).
module altmemddr_ex_lfsr8_checker #(
   parameter int SEED      = 32,
   parameter int LANES     = 1,
   parameter int NUM_BEATS = 256,
   parameter int CNT_W     = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               enable_i,
   input  logic               start_i,
   input  logic               rdata_valid_i,
   input  logic [8*LANES-1:0] rdata_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               pass_o,
   output logic               fail_o,
   output logic [CNT_W-1:0]   err_count_o,
   output logic [CNT_W-1:0]   first_err_beat_o,
   output logic [LANES-1:0]   lane_err_o
);

   localparam int               DW        = 8 * LANES;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One step of the generator LFSR; taps feed d7 back into bits 0, 2, 3 and 4.
   function automatic logic [7:0] lfsr_step(input logic [7:0] d);
      logic [7:0] n;
      n[0] = d[7];
      n[1] = d[0];
      n[2] = d[1] ^ d[7];
      n[3] = d[2] ^ d[7];
      n[4] = d[3] ^ d[7];
      n[5] = d[4];
      n[6] = d[5];
      n[7] = d[6];
      return n;
   endfunction

   state_t             state_q;
   logic [DW-1:0]      exp_q;
   logic [CNT_W-1:0]   beat_q;
   logic               done_q;
   logic               pass_q;
   logic               fail_q;
   logic [CNT_W-1:0]   err_cnt_q;
   logic [CNT_W-1:0]   first_err_q;
   logic [LANES-1:0]   lane_err_q;

   logic [DW-1:0]      seed_d;
   logic [DW-1:0]      exp_d;
   logic [LANES-1:0]   lane_mis_d;
   logic               beat_bad_d;

   // Seed pattern, per-lane compare and the expected bytes for the next beat.
   always_comb begin
      seed_d     = '0;
      exp_d      = '0;
      lane_mis_d = '0;
      for (int k = 0; k < LANES; k++) begin
         seed_d[8*k +: 8] = 8'((SEED + k) % 256);
         exp_d[8*k +: 8]  = lfsr_step(exp_q[8*k +: 8]);
         lane_mis_d[k]    = (rdata_i[8*k +: 8] != exp_q[8*k +: 8]);
      end
`ifdef ALTMEMDDR_CHK_RESYNC_EN
      // Beat 0 locks onto whatever the stream is showing instead of being judged.
      if (beat_q == '0) begin
         lane_mis_d = '0;
         for (int k = 0; k < LANES; k++) begin
            exp_d[8*k +: 8] = lfsr_step(rdata_i[8*k +: 8]);
         end
      end
`endif
      beat_bad_d = |lane_mis_d;
   end

   // Run control FSM plus expected-data and result registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         exp_q       <= seed_d;
         beat_q      <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         lane_err_q  <= '0;
      end else if (!enable_i) begin
         // Abandon any run; results stay visible to the status logic.
         state_q <= ST_IDLE;
         exp_q   <= seed_d;
         beat_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // Beats outside a run are ignored; only start does anything here.
               if (start_i) begin
                  state_q     <= ST_RUN;
                  exp_q       <= seed_d;
                  beat_q      <= '0;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  err_cnt_q   <= '0;
                  first_err_q <= '0;
                  lane_err_q  <= '0;
               end
            end
            ST_RUN: begin
               // start is ignored mid-run; idle cycles freeze the sequence.
               if (rdata_valid_i) begin
                  exp_q      <= exp_d;
                  beat_q     <= beat_q + CNT_ONE;
                  lane_err_q <= lane_err_q | lane_mis_d;
                  if (beat_bad_d) begin
                     fail_q <= 1'b1;
                     if (err_cnt_q != CNT_MAX) begin
                        err_cnt_q <= err_cnt_q + CNT_ONE;
                     end
                     if (!fail_q) begin
                        first_err_q <= beat_q;
                     end
                  end
                  if (beat_q == LAST_BEAT) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     pass_q  <= !(fail_q || beat_bad_d);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o           = (state_q == ST_RUN);
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign fail_o           = fail_q;
   assign err_count_o      = err_cnt_q;
   assign first_err_beat_o = first_err_q;
   assign lane_err_o       = lane_err_q;

endmodule

// File: tb/tb_altmemddr_ex_lfsr8_checker.sv
// Directed-vector bench for altmemddr_ex_lfsr8_checker.
// Three instances: 1 lane x 4 beats, 2-bit counters x 3 beats, 2 lanes x 2 beats.
// Inputs change on the falling edge; outputs are read on the falling edge after the sampling edge.
module tb_altmemddr_ex_lfsr8_checker;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        enable;
   logic        start;
   logic        valid;
   logic [15:0] rdata;
   int          sel;

   int          n_vec = 0;
   int          n_miscmp = 0;

   // instance A: 1 lane, 4 beats
   logic        a_start, a_vld, a_busy, a_done, a_pass, a_fail;
   logic [15:0] a_err, a_first;
   logic [0:0]  a_lane;
   // instance B: 2-bit counters, 3 beats
   logic        b_start, b_vld, b_busy, b_done, b_pass, b_fail;
   logic [1:0]  b_err, b_first;
   logic [0:0]  b_lane;
   // instance C: 2 lanes, 2 beats
   logic        c_start, c_vld, c_busy, c_done, c_pass, c_fail;
   logic [15:0] c_err, c_first;
   logic [1:0]  c_lane;

   assign a_start = start && (sel == 0);
   assign a_vld   = valid && (sel == 0);
   assign b_start = start && (sel == 1);
   assign b_vld   = valid && (sel == 1);
   assign c_start = start && (sel == 2);
   assign c_vld   = valid && (sel == 2);

   altmemddr_ex_lfsr8_checker #(.SEED(32), .LANES(1), .NUM_BEATS(4), .CNT_W(16)) u_a (
      .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .start_i(a_start),
      .rdata_valid_i(a_vld), .rdata_i(rdata[7:0]),
      .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail),
      .err_count_o(a_err), .first_err_beat_o(a_first), .lane_err_o(a_lane));

   altmemddr_ex_lfsr8_checker #(.SEED(32), .LANES(1), .NUM_BEATS(3), .CNT_W(2)) u_b (
      .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .start_i(b_start),
      .rdata_valid_i(b_vld), .rdata_i(rdata[7:0]),
      .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail),
      .err_count_o(b_err), .first_err_beat_o(b_first), .lane_err_o(b_lane));

   altmemddr_ex_lfsr8_checker #(.SEED(32), .LANES(2), .NUM_BEATS(2), .CNT_W(16)) u_c (
      .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .start_i(c_start),
      .rdata_valid_i(c_vld), .rdata_i(rdata),
      .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass), .fail_o(c_fail),
      .err_count_o(c_err), .first_err_beat_o(c_first), .lane_err_o(c_lane));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic beat(input logic [15:0] d);
      valid = 1'b1;
      rdata = d;
      @(negedge clk);
      valid = 1'b0;
      rdata = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Good 1-lane sequence from seed 0x20: 20, 40, 80, 1D.
   task automatic good_run_a();
      pulse_start();
      beat(16'h20); beat(16'h40); beat(16'h80); beat(16'h1D);
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b1; start = 1'b0; valid = 1'b0; rdata = '0; sel = 0;
      idle(2);
      // reset state
      chk("rst_busy",  32'(a_busy), 32'd0);
      chk("rst_done",  32'(a_done), 32'd0);
      chk("rst_pass",  32'(a_pass), 32'd0);
      chk("rst_fail",  32'(a_fail), 32'd0);
      chk("rst_err",   32'(a_err), 32'd0);
      chk("rst_first", 32'(a_first), 32'd0);
      chk("rst_lane",  32'(a_lane), 32'd0);
      reset_n = 1'b1;
      idle(1);

      // test 1: clean run
      pulse_start();
      chk("t1_busy_start", 32'(a_busy), 32'd1);
      beat(16'h20); beat(16'h40); beat(16'h80);
      chk("t1_done_early", 32'(a_done), 32'd0);
      beat(16'h1D);
      chk("t1_done", 32'(a_done), 32'd1);
      chk("t1_pass", 32'(a_pass), 32'd1);
      chk("t1_fail", 32'(a_fail), 32'd0);
      chk("t1_err",  32'(a_err), 32'd0);
      chk("t1_busy", 32'(a_busy), 32'd0);

      // test 2: beat 1 corrupted, restart from DONE
      pulse_start();
      chk("t2_done_clr", 32'(a_done), 32'd0);
      chk("t2_pass_clr", 32'(a_pass), 32'd0);
      beat(16'h20);
      chk("t2_fail_b0", 32'(a_fail), 32'd0);
      beat(16'h41);
      chk("t2_fail_b1", 32'(a_fail), 32'd1);
      chk("t2_first",   32'(a_first), 32'd1);
      chk("t2_err_b1",  32'(a_err), 32'd1);
      chk("t2_lane",    32'(a_lane), 32'd1);
      beat(16'h80); beat(16'h1D);
      chk("t2_done", 32'(a_done), 32'd1);
      chk("t2_pass", 32'(a_pass), 32'd0);
      chk("t2_err",  32'(a_err), 32'd1);
      // enable low returns to IDLE but holds results
      enable = 1'b0;
      idle(1);
      enable = 1'b1;
      chk("en_hold_fail", 32'(a_fail), 32'd1);
      chk("en_hold_err",  32'(a_err), 32'd1);
      chk("en_hold_done", 32'(a_done), 32'd1);

      // test 3: gaps, valid in start cycle ignored, start mid-run ignored
      start = 1'b1; valid = 1'b1; rdata = 16'h55;
      @(negedge clk);
      start = 1'b0; valid = 1'b0; rdata = '0;
      beat(16'h20);
      idle(2);
      chk("t3_busy_gap", 32'(a_busy), 32'd1);
      pulse_start();
      beat(16'h40);
      beat(16'h80);
      idle(3);
      chk("t3_busy_gap2", 32'(a_busy), 32'd1);
      chk("t3_done_early", 32'(a_done), 32'd0);
      beat(16'h1D);
      chk("t3_done", 32'(a_done), 32'd1);
      chk("t3_pass", 32'(a_pass), 32'd1);
      chk("t3_err",  32'(a_err), 32'd0);
      chk("t3_busy", 32'(a_busy), 32'd0);

      // test 4: reset in mid-run, then a clean run
      pulse_start();
      beat(16'h20); beat(16'h40);
      reset_n = 1'b0;
      idle(1);
      chk("t4_busy", 32'(a_busy), 32'd0);
      chk("t4_done", 32'(a_done), 32'd0);
      chk("t4_pass", 32'(a_pass), 32'd0);
      reset_n = 1'b1;
      idle(1);
      good_run_a();
      chk("t4_pass_after", 32'(a_pass), 32'd1);

      // enable low mid-run, beats in IDLE ignored, next start begins at beat 0
      pulse_start();
      beat(16'h20); beat(16'h40);
      enable = 1'b0;
      idle(1);
      enable = 1'b1;
      chk("en_run_busy", 32'(a_busy), 32'd0);
      beat(16'h00);
      chk("idle_beat_fail", 32'(a_fail), 32'd0);
      chk("idle_beat_done", 32'(a_done), 32'd0);
      good_run_a();
      chk("en_rerun_pass", 32'(a_pass), 32'd1);
      chk("en_rerun_done", 32'(a_done), 32'd1);

      // test 6 (default build compares beat 0 against the seed)
      pulse_start();
      beat(16'h80); beat(16'h1D); beat(16'h3A); beat(16'h74);
      chk("t6_done", 32'(a_done), 32'd1);
`ifdef ALTMEMDDR_CHK_RESYNC_EN
      chk("t6_pass", 32'(a_pass), 32'd1);
      chk("t6_fail", 32'(a_fail), 32'd0);
`else
      chk("t6_fail",  32'(a_fail), 32'd1);
      chk("t6_first", 32'(a_first), 32'd0);
      chk("t6_err",   32'(a_err), 32'd4);
`endif

      // test 5: 2-bit counters, three all-zero runs
      sel = 1;
      for (int r = 0; r < 3; r++) begin
         pulse_start();
         beat(16'h00); beat(16'h00); beat(16'h00);
         chk("t5_err",   32'(b_err), 32'd3);
         chk("t5_first", 32'(b_first), 32'd0);
         chk("t5_done",  32'(b_done), 32'd1);
      end
      beat(16'h00);
      chk("t5_err_hold", 32'(b_err), 32'd3);
      chk("t5_pass", 32'(b_pass), 32'd0);

      // two lanes: lane 1 expects 21 then 42; corrupt lane 1 on beat 1
      sel = 2;
      pulse_start();
      beat(16'h2120);
      chk("ln_fail_b0", 32'(c_fail), 32'd0);
      beat(16'h4340);
      chk("ln_lane",  32'(c_lane), 32'd2);
      chk("ln_first", 32'(c_first), 32'd1);
      chk("ln_err",   32'(c_err), 32'd1);
      chk("ln_done",  32'(c_done), 32'd1);
      pulse_start();
      beat(16'h2120); beat(16'h4240);
      chk("ln_pass", 32'(c_pass), 32'd1);
      chk("ln_lane_clr", 32'(c_lane), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
